// File: rtl/reg_dump_pkg.sv
// ============================================================================
// Module : reg_dump_pkg
// Brief  : Shared types and defaults for the register-file dump reader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package reg_dump_pkg;

   localparam int NUM_REGS_DEF = 32;
   localparam int ADDR_W_DEF   = 5;
   localparam int DATA_W_DEF   = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam state_t RESET_STATE = ST_IDLE;

endpackage

`default_nettype wire

// File: rtl/reg_dump_if.sv
// ============================================================================
// Module : reg_dump_if
// Brief  : Control, register-file read port and dump stream of the reader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface reg_dump_if
   import reg_dump_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              Start;
   logic [ADDR_W-1:0] Start_index;
   logic [ADDR_W-1:0] End_index;
   logic [ADDR_W-1:0] Read_register;
   logic [DATA_W-1:0] Read_data;
   logic              Dump_valid;
   logic              Dump_ready;
   logic [ADDR_W-1:0] Dump_index;
   logic [DATA_W-1:0] Dump_data;
   logic              Busy;
   logic              Done;

   modport slave (
      input  Start, Start_index, End_index, Read_data, Dump_ready,
      output Read_register, Dump_valid, Dump_index, Dump_data, Busy, Done
   );

   modport master (
      output Start, Start_index, End_index, Read_data, Dump_ready,
      input  Read_register, Dump_valid, Dump_index, Dump_data, Busy, Done
   );

endinterface

`default_nettype wire

// File: rtl/reg_dump_reader.sv
// ============================================================================
// Module : reg_dump_reader
// Brief  : Walks an inclusive, wrapping register index range and streams
//          each (index, value) pair on a valid/ready interface.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_dump_reader
   import reg_dump_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF
)(
   input  logic       CLK,
   input  logic       RESET,
   reg_dump_if.slave  bus
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_end;
   logic              r_dump_valid;
   logic [ADDR_W-1:0] r_dump_index;
   logic [DATA_W-1:0] r_dump_data;

   logic              w_load;
   logic [ADDR_W-1:0] w_ptr_next;
   logic [ADDR_W-1:0] w_read_register;

   // The output register may be refilled when empty or being drained this cycle.
   assign w_load     = !r_dump_valid || bus.Dump_ready;
   assign w_ptr_next = (r_ptr == ADDR_W'(NUM_REGS - 1)) ? '0 : r_ptr + ADDR_W'(1);

   always_comb begin
      w_read_register = '0;
      case (r_state)
         ST_STREAM: w_read_register = r_ptr;
         ST_DRAIN:  w_read_register = r_end;
         default:   w_read_register = '0;
      endcase
   end

   assign bus.Read_register = w_read_register;
   assign bus.Dump_valid    = r_dump_valid;
   assign bus.Dump_index    = r_dump_index;
   assign bus.Dump_data     = r_dump_data;
   assign bus.Busy          = (r_state == ST_STREAM) || (r_state == ST_DRAIN);
   assign bus.Done          = (r_state == ST_DONE);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state      <= RESET_STATE;
         r_ptr        <= '0;
         r_end        <= '0;
         r_dump_valid <= 1'b0;
         r_dump_index <= '0;
         r_dump_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.Start) begin
                  r_ptr   <= bus.Start_index;
                  r_end   <= bus.End_index;
                  r_state <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (w_load) begin
                  r_dump_data  <= bus.Read_data;
                  r_dump_index <= r_ptr;
                  r_dump_valid <= 1'b1;
                  if (r_ptr == r_end) begin
                     r_state <= ST_DRAIN;
                  end else begin
                     r_ptr <= w_ptr_next;
                  end
               end
            end
            ST_DRAIN: begin
               if (bus.Dump_ready) begin
                  r_dump_valid <= 1'b0;
                  r_state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= RESET_STATE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
// ============================================================================
// Module : tb_reg_dump_reader
// Brief  : Directed self-checking bench for reg_dump_reader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_dump_reader;

   logic CLK = 1'b0;
   logic RESET;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [31:0] rf [32];

   reg_dump_if #(.ADDR_W(5), .DATA_W(32)) bus ();

   reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) u_dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   assign bus.Read_data = rf[bus.Read_register];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // $gp = r28, $sp = r29; every other register holds 0x100 + k.
   function automatic logic [31:0] reg_val(input int k);
      if (k == 28) return 32'h1000_8000;
      if (k == 29) return 32'h0000_0180;
      return 32'h100 + 32'(k);
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd_reg"}, 32'(bus.Read_register), 32'd0);
      chk({tag, "_valid"},  32'(bus.Dump_valid),    32'd0);
      chk({tag, "_index"},  32'(bus.Dump_index),    32'd0);
      chk({tag, "_data"},   bus.Dump_data,          32'd0);
      chk({tag, "_busy"},   32'(bus.Busy),          32'd0);
      chk({tag, "_done"},   32'(bus.Done),          32'd0);
   endtask

   // mode 0: ready always high; mode 1: ready 1,0,0 repeating;
   // mode 2: ready high with a conflicting Start pulse mid-dump.
   task automatic do_dump(input string tag, input logic [4:0] s, input logic [4:0] e,
                          input int mode, input int n_exp);
      int          cyc       = 1;
      int          got       = 0;
      int          last_hs   = -10;
      int          first_v   = -1;
      bit          done_seen = 1'b0;
      bit          stalled   = 1'b0;
      bit          busy_ok   = 1'b1;
      logic [4:0]  held_idx  = '0;
      logic [31:0] held_data = '0;
      logic [4:0]  exp_idx;

      bus.Start       = 1'b1;
      bus.Start_index = s;
      bus.End_index   = e;
      tick();
      bus.Start = 1'b0;

      while (!done_seen && cyc < 300) begin
         bus.Dump_ready = (mode == 1) ? (cyc % 3 == 1) : 1'b1;
         if (mode == 2 && cyc == 5) begin
            bus.Start       = 1'b1;
            bus.Start_index = s + 5'd7;
            bus.End_index   = s + 5'd1;
         end else begin
            bus.Start = 1'b0;
         end

         if (bus.Dump_valid && first_v < 0) first_v = cyc;
         if (bus.Dump_valid && stalled) begin
            chk({tag, "_hold_idx"},  32'(bus.Dump_index), 32'(held_idx));
            chk({tag, "_hold_data"}, bus.Dump_data,       held_data);
         end
         if (bus.Dump_valid && bus.Dump_ready) begin
            exp_idx = s + 5'(got);
            chk({tag, "_idx"},  32'(bus.Dump_index), 32'(exp_idx));
            chk({tag, "_data"}, bus.Dump_data,       reg_val(int'(exp_idx)));
            got++;
            last_hs = cyc;
            stalled = 1'b0;
         end else if (bus.Dump_valid) begin
            stalled   = 1'b1;
            held_idx  = bus.Dump_index;
            held_data = bus.Dump_data;
         end

         if (bus.Done) begin
            done_seen = 1'b1;
            chk({tag, "_done_lat"},     32'(cyc),      32'(last_hs + 1));
            chk({tag, "_busy_at_done"}, 32'(bus.Busy), 32'd0);
         end else if (!bus.Busy) begin
            busy_ok = 1'b0;
         end
         tick();
         cyc++;
      end
      bus.Start = 1'b0;

      chk({tag, "_beats"},      32'(got),       32'(n_exp));
      chk({tag, "_first_v"},    32'(first_v),   32'd2);
      chk({tag, "_done_seen"},  32'(done_seen), 32'd1);
      chk({tag, "_busy_held"},  32'(busy_ok),   32'd1);
      chk({tag, "_done_pulse"}, 32'(bus.Done),  32'd0);
      chk({tag, "_idle_busy"},  32'(bus.Busy),  32'd0);
      chk({tag, "_idle_valid"}, 32'(bus.Dump_valid), 32'd0);
   endtask

   initial begin
      bit done_after_rst;

      for (int k = 0; k < 32; k++) rf[k] = reg_val(k);
      RESET           = 1'b1;
      bus.Start       = 1'b0;
      bus.Start_index = '0;
      bus.End_index   = '0;
      bus.Dump_ready  = 1'b0;
      tick();
      tick();
      chk_reset_outputs("reset");
      RESET = 1'b0;
      tick();

      do_dump("full",       5'd0,  5'd31, 0, 32);
      do_dump("wrap",       5'd30, 5'd1,  0, 4);
      do_dump("single",     5'd29, 5'd29, 0, 1);
      do_dump("bp",         5'd8,  5'd12, 1, 5);
      do_dump("busy_start", 5'd10, 5'd20, 2, 11);
      do_dump("wrap_all",   5'd5,  5'd4,  0, 32);

      // Abort a full dump while beat 3 is on the bus.
      bus.Start       = 1'b1;
      bus.Start_index = 5'd0;
      bus.End_index   = 5'd31;
      bus.Dump_ready  = 1'b1;
      tick();
      bus.Start = 1'b0;
      repeat (4) tick();
      chk("rst_pre_idx", 32'(bus.Dump_index), 32'd3);
      RESET = 1'b1;
      tick();
      chk_reset_outputs("rst_mid");
      RESET = 1'b0;
      done_after_rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus.Done || bus.Dump_valid) done_after_rst = 1'b1;
         tick();
      end
      chk("rst_no_done", 32'(done_after_rst), 32'd0);
      do_dump("after_rst", 5'd3, 5'd6, 0, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
